// File: rtl/tag_alloc_free_pkg.sv
// tag_alloc_free_pkg: shared types and constants for the tag free-list
package tag_alloc_free_pkg;
  localparam int NENT = 96;
  localparam int TW = 7;
  typedef logic [TW-1:0] tag_t;
  typedef logic [7:0] cnt_t;
  typedef logic [NENT-1:0] map_t;
  localparam tag_t TAG_NONE = 7'd127;
endpackage

// File: rtl/tag_alloc_free_flz96.sv
// tag_alloc_free_flz96: index of the lowest zero bit in a 96-bit map, TAG_NONE if all ones
module tag_alloc_free_flz96
  import tag_alloc_free_pkg::*;
(
  input  map_t map,
  output tag_t idx
);
  // scan from the top so the lowest free index wins
  always_comb begin
    idx = TAG_NONE;
    for (int i = NENT - 1; i >= 0; i--)
      idx = map[i] ? idx : tag_t'(i);
  end
endmodule

// File: rtl/tag_alloc_free.sv
// tag_alloc_free: 96-entry bitmap free-list with one allocate and one free port per clock
module tag_alloc_free
  import tag_alloc_free_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          alloc_req,
  output logic          alloc_rdy,
  output logic          alloc_vld,
  output logic [TW-1:0] alloc_tag,
  input  logic          free_req,
  input  logic [TW-1:0] free_tag,
  output logic          free_err,
  output logic [7:0]    free_cnt,
  output logic          full,
  output logic          empty
);
  map_t bitmap_q, bitmap_d, set_m, clr_m;
  cnt_t cnt_q, cnt_d;
  tag_t tag_q, tag_d, grant;
  logic vld_q, vld_d, err_q, err_d, full_q, full_d, empty_q, empty_d;
  logic fire, hit, legal;

  tag_alloc_free_flz96 u_flz (.map(bitmap_q), .idx(grant));

  assign alloc_rdy = grant != TAG_NONE;
  assign alloc_vld = vld_q;
  assign alloc_tag = tag_q;
  assign free_err  = err_q;
  assign free_cnt  = cnt_q;
  assign full      = full_q;
  assign empty     = empty_q;

  // accept/legality decisions, bitmap update masks and next counter
  always_comb begin
    fire     = alloc_req && alloc_rdy && !clear;
    hit      = free_tag < tag_t'(NENT) && bitmap_q[free_tag];
    legal    = free_req && !clear && hit;
    err_d    = free_req && !clear && !hit;
    set_m    = fire ? map_t'(1) << grant : '0;
    clr_m    = legal ? map_t'(1) << free_tag : '0;
    bitmap_d = clear ? '0 : (bitmap_q | set_m) & ~clr_m;
    cnt_d    = clear ? cnt_t'(NENT) : cnt_q - cnt_t'(fire) + cnt_t'(legal);
    full_d   = cnt_d == '0;
    empty_d  = cnt_d == cnt_t'(NENT);
    vld_d    = fire;
    tag_d    = fire ? grant : tag_q;
  end

  // state registers with asynchronous reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bitmap_q <= '0;
      cnt_q    <= cnt_t'(NENT);
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      vld_q    <= 1'b0;
      tag_q    <= TAG_NONE;
      err_q    <= 1'b0;
    end else begin
      bitmap_q <= bitmap_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      vld_q    <= vld_d;
      tag_q    <= tag_d;
      err_q    <= err_d;
    end
endmodule

// File: tb/tb_tag_alloc_free.sv
// tb_tag_alloc_free: scoreboard bench for the tag free-list
module tb_tag_alloc_free;
  logic clk = 0, rst = 1, clear = 0, alloc_req = 0, free_req = 0;
  logic [6:0] free_tag = 0;
  logic alloc_rdy, alloc_vld, free_err, full, empty;
  logic [6:0] alloc_tag;
  logic [7:0] free_cnt;
  int vectors = 0, miscompares = 0;
  bit [95:0] mbits = 0;
  int mcnt = 96, mtag = 127;
  typedef struct {bit vld; int tag; bit err; int cnt;} exp_t;
  exp_t sb[$];

  tag_alloc_free dut (
    .clk(clk), .rst(rst), .clear(clear), .alloc_req(alloc_req), .alloc_rdy(alloc_rdy),
    .alloc_vld(alloc_vld), .alloc_tag(alloc_tag), .free_req(free_req), .free_tag(free_tag),
    .free_err(free_err), .free_cnt(free_cnt), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got %0d exp %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input bit a, input bit f, input int t, input bit c);
    exp_t e;
    int g;
    bit fire, legal, err;
    @(negedge clk);
    alloc_req = a; free_req = f; free_tag = 7'(t); clear = c;
    #1 chk("alloc_rdy", alloc_rdy, mcnt != 0);
    g = 127;
    for (int i = 95; i >= 0; i--) if (!mbits[i]) g = i;
    fire  = a && mcnt != 0 && !c;
    legal = f && !c && t < 96 && mbits[t];
    err   = f && !c && !legal;
    if (c) begin
      mbits = 0; mcnt = 96;
    end else begin
      if (fire) begin mbits[g] = 1; mcnt--; mtag = g; end
      if (legal) begin mbits[t] = 0; mcnt++; end
    end
    e = '{fire, mtag, err, mcnt};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("alloc_vld", alloc_vld, e.vld);
    chk("alloc_tag", alloc_tag, e.tag);
    chk("free_err", free_err, e.err);
    chk("free_cnt", free_cnt, e.cnt);
    chk("full", full, e.cnt == 0);
    chk("empty", empty, e.cnt == 96);
  endtask

  task automatic check_reset_state();
    chk("rst_cnt", free_cnt, 96);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_vld", alloc_vld, 0);
    chk("rst_tag", alloc_tag, 127);
    chk("rst_err", free_err, 0);
  endtask

  initial begin
    #12 check_reset_state();
    @(negedge clk) rst = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      chk("burst_tag", alloc_tag, i);
      chk("burst_cnt", free_cnt, 95 - i);
    end
    for (int i = 0; i < 93; i++) step(1, 0, 0, 0);
    chk("last_tag", alloc_tag, 95);
    chk("full_flag", full, 1);
    chk("full_rdy", alloc_rdy, 0);
    step(1, 0, 0, 0);
    chk("full_novld", alloc_vld, 0);
    chk("full_cnt", free_cnt, 0);
    step(1, 1, 40, 0);
    chk("free40_novld", alloc_vld, 0);
    step(1, 0, 0, 0);
    chk("regrant40", alloc_tag, 40);
    chk("regrant_cnt", free_cnt, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    step(0, 1, 5, 0);
    chk("free5_cnt", free_cnt, 87);
    step(0, 1, 5, 0);
    chk("dbl_err", free_err, 1);
    chk("dbl_cnt", free_cnt, 87);
    step(0, 0, 0, 0);
    chk("err_pulse", free_err, 0);
    step(0, 1, 100, 0);
    chk("oor_err", free_err, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    step(1, 1, 3, 0);
    chk("simul_tag", alloc_tag, 5);
    chk("simul_cnt", free_cnt, 91);
    step(1, 0, 0, 0);
    chk("simul_next", alloc_tag, 3);
    step(1, 1, 4, 0);
    step(1, 1, 0, 1);
    chk("clr_novld", alloc_vld, 0);
    chk("clr_err", free_err, 0);
    chk("clr_cnt", free_cnt, 96);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    @(negedge clk);
    alloc_req = 0; free_req = 0; clear = 0; rst = 1;
    #2 check_reset_state();
    mbits = 0; mcnt = 96; mtag = 127;
    @(negedge clk) rst = 0;
    #1 chk("post_rst_vld", alloc_vld, 0);
    step(1, 0, 0, 0);
    chk("post_rst_tag", alloc_tag, 0);
    step(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
